motor_cmd_seq: RTL



---
 rtl/motor_cmd_seq.sv | 156 +++++++++++++++
 1 files changed

// File: rtl/motor_cmd_seq.sv
// Two-side motor command sequencer: slew-limited ramp per side with a zero-speed
// brake dwell inserted on every direction reversal; all outputs are registered.
module motor_cmd_seq #(
    parameter int unsigned STEP        = 64,
    parameter int unsigned TICK_DIV    = 1000,
    parameter int unsigned BRAKE_TICKS = 8
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               cmd_vld,
    input  logic signed [10:0] cmd_lft,
    input  logic signed [10:0] cmd_rht,
    output logic               cmd_rdy,
    input  logic               estop,
    output logic signed [10:0] lft,
    output logic signed [10:0] rht,
    output logic               busy
);

    localparam int unsigned CW = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
    localparam int unsigned DW = (BRAKE_TICKS > 1) ? $clog2(BRAKE_TICKS + 1) : 1;
    localparam logic signed [11:0] STEP12     = 12'(STEP);
    localparam logic [CW-1:0]      TICK_LAST  = CW'(TICK_DIV - 1);
    localparam logic [DW-1:0]      DWELL_INIT = DW'(BRAKE_TICKS);

    typedef enum logic {
        RUN = 1'b0,
        BRK = 1'b1
    } side_state_t;

    side_state_t        st_q    [2];
    side_state_t        st_d    [2];
    logic [DW-1:0]      dwell_q [2];
    logic [DW-1:0]      dwell_d [2];
    logic signed [10:0] cur_q   [2];
    logic signed [10:0] cur_d   [2];
    logic signed [10:0] tgt_q   [2];
    logic signed [10:0] tgt_d   [2];
    logic signed [10:0] cmd_sat [2];
    logic [CW-1:0]      cnt_q;
    logic [CW-1:0]      cnt_d;
    logic               tick;
    logic               take;
    logic               busy_d;
    logic               rdy_d;

    function automatic logic signed [10:0] sat11(input logic signed [10:0] v);
        return (v == 11'h400) ? 11'h401 : v;
    endfunction

    // One ramp/dwell update for a single side; 12-bit intermediates keep
    // tgt-cur and the stepped value from wrapping.
    function automatic void side_step(
        input  side_state_t        st,
        input  logic [DW-1:0]      dw,
        input  logic signed [10:0] cur,
        input  logic signed [10:0] tgt,
        output side_state_t        st_n,
        output logic [DW-1:0]      dw_n,
        output logic signed [10:0] cur_n
    );
        logic signed [11:0] c12;
        logic signed [11:0] d12;
        logic signed [11:0] mag_c;
        logic signed [11:0] mag_d;
        c12   = {cur[10], cur};
        d12   = {tgt[10], tgt} - c12;
        mag_c = c12[11] ? -c12 : c12;
        mag_d = d12[11] ? -d12 : d12;
        st_n  = st;
        dw_n  = dw;
        cur_n = cur;
        if (st == BRK) begin
            dw_n = dw - 1'b1;
            if (dw == DW'(1)) begin
                st_n = RUN;
            end
        end else if (cur != '0 && tgt != '0 && cur[10] != tgt[10]) begin
            if (mag_c <= STEP12) begin
                cur_n = '0;
                st_n  = BRK;
                dw_n  = DWELL_INIT;
            end else begin
                cur_n = c12[11] ? 11'(c12 + STEP12) : 11'(c12 - STEP12);
            end
        end else if (mag_d <= STEP12) begin
            cur_n = tgt;
        end else begin
            cur_n = d12[11] ? 11'(c12 - STEP12) : 11'(c12 + STEP12);
        end
    endfunction

    assign cmd_sat[0] = sat11(cmd_lft);
    assign cmd_sat[1] = sat11(cmd_rht);
    assign tick       = (cnt_q == TICK_LAST);
    assign take       = cmd_vld & cmd_rdy & ~estop;
    assign lft        = cur_q[0];
    assign rht        = cur_q[1];

    // State register
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int unsigned i = 0; i < 2; i++) begin
                st_q[i]    <= RUN;
                dwell_q[i] <= '0;
                cur_q[i]   <= '0;
                tgt_q[i]   <= '0;
            end
            cnt_q   <= '0;
            busy    <= 1'b0;
            cmd_rdy <= 1'b1;
        end else begin
            for (int unsigned i = 0; i < 2; i++) begin
                st_q[i]    <= st_d[i];
                dwell_q[i] <= dwell_d[i];
                cur_q[i]   <= cur_d[i];
                tgt_q[i]   <= tgt_d[i];
            end
            cnt_q   <= cnt_d;
            busy    <= busy_d;
            cmd_rdy <= rdy_d;
        end
    end

    // Next-state logic; a tick on the capture edge still uses the old targets
    always_comb begin
        cnt_d = tick ? '0 : cnt_q + 1'b1;
        for (int unsigned i = 0; i < 2; i++) begin
            st_d[i]    = st_q[i];
            dwell_d[i] = dwell_q[i];
            cur_d[i]   = cur_q[i];
            tgt_d[i]   = take ? cmd_sat[i] : tgt_q[i];
            if (tick) begin
                side_step(st_q[i], dwell_q[i], cur_q[i], tgt_q[i],
                          st_d[i], dwell_d[i], cur_d[i]);
            end
        end
        if (estop) begin
            cnt_d = '0;
            for (int unsigned i = 0; i < 2; i++) begin
                st_d[i]    = RUN;
                dwell_d[i] = '0;
                cur_d[i]   = '0;
                tgt_d[i]   = '0;
            end
        end
    end

    // Registered status outputs are decoded from the next state
    always_comb begin
        busy_d = (cur_d[0] != tgt_d[0]) || (cur_d[1] != tgt_d[1]) ||
                 (st_d[0] == BRK) || (st_d[1] == BRK);
        rdy_d  = !estop && (st_d[0] == RUN) && (st_d[1] == RUN);
    end

endmodule
